pragmatic_mac_seq: RTL and testbench
====================================

Name: pragmatic_mac_seq

Overview:
- Self-scheduling Pragmatic bit-serial MAC for one dot-product lane group.
- Accepts VEC_LENGTH signed activation/weight pairs and encodes each weight's essential bits internally.
- Issues one essential bit per lane per cycle through a two-stage shifter (per-lane offset plus common base), then accumulates across groups.
- Successor to the externally-scheduled Pragmatic MAC: adds internal term scheduling, valid/ready handshakes, group first/last control and generic widths.

Parameters:
DATA_WIDTH, 8, activation and weight width (signed)
VEC_LENGTH, 8, lanes; power of 2, at least 2
OFFSET_WIDTH, 2, per-lane offset select bits; window = 2**OFFSET_WIDTH bit positions
ACC_WIDTH, DATA_WIDTH+16, accumulator width
RESULT_WIDTH, 2*DATA_WIDTH, output slice width; must be at most ACC_WIDTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand group valid
in_ready  out  1  block can accept a group
in_first  in  1  clear accumulator before this group
in_last  in  1  emit result after this group
act  in  VEC_LENGTH x DATA_WIDTH  signed activations
weight  in  VEC_LENGTH x DATA_WIDTH  signed weights
out_valid  out  1  result valid
out_ready  in  1  result consumed
result  out  RESULT_WIDTH  acc[ACC_WIDTH-1 -: RESULT_WIDTH]

Behaviour:
- Reset (async, reset_n=0): state IDLE, acc=0, psum_reg=0, out_valid=0, result=0. in_ready=1 once reset is released. Reset mid-operation aborts the group with no output.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid:
  - latch act, |weight| (DATA_WIDTH-bit unsigned magnitude; -2^(DATA_WIDTH-1) is legal), sign, in_last.
  - if in_first, set acc to 0 in the same cycle.
  - go to RUN.
- RUN, one round per cycle:
  - per lane, pos = index of lowest set bit of the remaining magnitude.
  - base = min of pos over non-zero lanes.
  - lane enabled iff magnitude is non-zero and pos-base < 2**OFFSET_WIDTH; enabled lanes clear bit pos. Other lanes stall and issue 0.
  - term = (sign ? -act : act), sign-extended to DATA_WIDTH+1 bits so that -(-128)=+128, then << (pos-base).
  - adder tree sum is shifted << base; the result is registered into psum_reg at width DATA_WIDTH+1+(2**OFFSET_WIDTH-1)+log2(VEC_LENGTH)+DATA_WIDTH.
  - go to DRAIN when all magnitudes are zero after this round.
  - an all-zero group still spends exactly 1 RUN cycle and contributes 0.
- DRAIN: one cycle; psum_reg is sign-extended and added to acc with two's-complement wrap. Then DONE if last, else IDLE.
- DONE: out_valid=1, result stable; hold until out_ready, then IDLE. in_ready=0 in RUN, DRAIN and DONE.
- Acc add pipeline: psum_reg captures every RUN cycle; acc adds psum_reg every cycle after the first RUN cycle through DRAIN. Every issued round is accumulated exactly once.
- Latency, accept to out_valid: R+2 cycles, where R = RUN rounds (at least 1). Minimum R=1, maximum R=DATA_WIDTH.
- out_valid and out_ready together in the same cycle: transfer completes; the block re-accepts one cycle later (IDLE).

Optional Feature:
- Macro PRAGMATIC_MAC_STATS_EN.
- Defined: extra outputs stat_rounds (16 bits, total RUN cycles) and stat_stalls (16 bits, total lane-stall events, i.e. lanes non-zero but not enabled).
  - both saturate at 0xFFFF.
  - cleared by reset and on acceptance of an in_first group.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package pragmatic_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE).
  - localparams POS_WIDTH=$clog2(DATA_WIDTH), TERM_WIDTH, PSUM_WIDTH.
  - function lowest_set_index.
- One sub-module, pragmatic_lane_encoder: per-lane magnitude register, lowest-bit detect, offset/enable compute and bit clear. Instantiated VEC_LENGTH times.
- Min-reduction, adder tree, FSM and accumulator stay in the top level.

Test Plan:
- Bench instance ACC_WIDTH=16, RESULT_WIDTH=16. act0=3, w0=5, other lanes 0, first=last=1 -> R=2, out_valid 4 cycles after accept, result=15.
- Same instance, lane-window stall: act0=2, w0=1; act1=1, w1=32 -> round1 lane1 stalls, round2 base=5; R=2, result=34; with STATS_EN, stat_stalls=1.
- Default widths: all lanes act=-128, w=-128, first=last=1 -> R=1, acc=131072, result=512.
- Three groups (first on group 1, last on group 3), each act0=1, w0=-1, others 0 -> out_valid once only, result=-3 (ACC_WIDTH=16 instance). No out_valid after groups 1 and 2.
- All weights 0 -> R=1, result=0. Hold out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0. Then out_ready=1 -> next cycle in_ready=1.
- Drop reset_n during RUN of a 3-round group -> out_valid=0, acc=0, in_ready=1 after release. A following group is processed correctly.

Source files
------------

// File: rtl/pragmatic_pkg.sv
// pragmatic_pkg: shared types and helpers for the Pragmatic bit-serial MAC.
//   state_t            - sequencer states
//   pos_width()        - bits needed to index a bit of a DATA_WIDTH word
//   term_width()       - width of one offset-shifted lane term
//   psum_width()       - width of the registered per-round partial sum
//   lowest_set_index() - index of the lowest set bit (0 when the word is zero)
// POS_WIDTH/TERM_WIDTH/PSUM_WIDTH are the values for the default configuration;
// the top level recomputes them from its own parameters via the functions.
package pragmatic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_VEC_LENGTH   = 8;
  localparam int DEF_OFFSET_WIDTH = 2;

  function automatic int pos_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // sign-extended activation (dw+1) plus the largest in-window shift
  function automatic int term_width(input int dw, input int ow);
    return dw + 1 + (2**ow - 1);
  endfunction

  // lane term, adder-tree growth, then up to dw-1 bits of common base shift
  function automatic int psum_width(input int dw, input int ow, input int vl);
    return term_width(dw, ow) + $clog2(vl) + dw;
  endfunction

  localparam int POS_WIDTH  = pos_width(DEF_DATA_WIDTH);
  localparam int TERM_WIDTH = term_width(DEF_DATA_WIDTH, DEF_OFFSET_WIDTH);
  localparam int PSUM_WIDTH = psum_width(DEF_DATA_WIDTH, DEF_OFFSET_WIDTH, DEF_VEC_LENGTH);

  function automatic int unsigned lowest_set_index(input logic [63:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 63; i >= 0; i--)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/pragmatic_mac_seq_lane.sv
// pragmatic_lane_encoder: one lane of essential-bit scheduling.
//   clk, reset_n  clock / async active-low reset
//   load          capture |weight| and its sign (group acceptance)
//   advance       consume the issued bit this cycle (RUN)
//   weight        signed weight for this lane
//   base          common base position chosen across all lanes
//   nz            remaining magnitude is non-zero
//   en            lane issues a bit this round (within the offset window)
//   sign          latched weight sign
//   pos           lowest set bit of remaining magnitude
//   offset        pos - base, valid when en
//   empty_next    remaining magnitude will be zero after this round
module pragmatic_lane_encoder
  import pragmatic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 2,
  parameter int POS_W        = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    advance,
  input  logic [DATA_WIDTH-1:0]   weight,
  input  logic [POS_W-1:0]        base,
  output logic                    nz,
  output logic                    en,
  output logic                    sign,
  output logic [POS_W-1:0]        pos,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    empty_next
);

  logic [DATA_WIDTH-1:0] mag, mag_in, mag_nxt, bit_mask;
  logic [POS_W:0]        diff;

  // two's-complement negate; -2^(DW-1) maps to the unsigned 2^(DW-1)
  assign mag_in = weight[DATA_WIDTH-1] ? (~weight + DATA_WIDTH'(1)) : weight;

  always_comb begin
    nz         = |mag;
    pos        = POS_W'(lowest_set_index(64'(mag)));
    diff       = {1'b0, pos} - {1'b0, base};
    en         = nz && (int'(diff) < (1 << OFFSET_WIDTH));
    offset     = OFFSET_WIDTH'(diff);
    bit_mask   = en ? (DATA_WIDTH'(1) << pos) : '0;
    mag_nxt    = mag & ~bit_mask;
    empty_next = ~|mag_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag  <= '0;
      sign <= 1'b0;
    end else if (load) begin
      mag  <= mag_in;
      sign <= weight[DATA_WIDTH-1];
    end else if (advance) begin
      mag  <= mag_nxt;
    end
  end

endmodule

// File: rtl/pragmatic_mac_seq.sv
// pragmatic_mac_seq: self-scheduling Pragmatic bit-serial MAC, one lane group.
//   clk, reset_n         clock / async active-low reset
//   in_valid/in_ready    operand group handshake
//   in_first             clear accumulator when this group is accepted
//   in_last              present result after this group
//   act, weight          VEC_LENGTH signed activation / weight pairs
//   out_valid/out_ready  result handshake
//   result               acc[ACC_WIDTH-1 -: RESULT_WIDTH]
// Optional (PRAGMATIC_MAC_STATS_EN): stat_rounds, stat_stalls saturating counters.
// Each RUN round issues at most one essential weight bit per lane; lanes whose
// bit lies outside the 2**OFFSET_WIDTH window above the common base stall.
module pragmatic_mac_seq
  import pragmatic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 8,
  parameter int OFFSET_WIDTH = 2,
  parameter int ACC_WIDTH    = DATA_WIDTH + 16,
  parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_first,
  input  logic                                   in_last,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  weight,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RESULT_WIDTH-1:0]                result
`ifdef PRAGMATIC_MAC_STATS_EN
  ,
  output logic [15:0]                            stat_rounds,
  output logic [15:0]                            stat_stalls
`endif
);

  localparam int PW  = pos_width(DATA_WIDTH);
  localparam int TW  = term_width(DATA_WIDTH, OFFSET_WIDTH);
  localparam int SW  = TW + $clog2(VEC_LENGTH);
  localparam int PSW = psum_width(DATA_WIDTH, OFFSET_WIDTH, VEC_LENGTH);

  state_t state, state_nxt;
  logic   accept, last_q, all_empty, any_nz;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_q;
  logic [VEC_LENGTH-1:0]                   nz, en, sign, empty_next;
  logic [VEC_LENGTH-1:0][PW-1:0]           pos;
  logic [VEC_LENGTH-1:0][OFFSET_WIDTH-1:0] offset;
  logic [PW-1:0]                           base;

  logic [SW-1:0]               sum;
  logic [PSW-1:0]              psum_nxt;
  logic signed [PSW-1:0]       psum_reg;
  logic signed [ACC_WIDTH-1:0] psum_ext, acc;

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc[ACC_WIDTH-1 -: RESULT_WIDTH];
  assign all_empty = &empty_next;

  for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
    pragmatic_lane_encoder #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OFFSET_WIDTH (OFFSET_WIDTH),
      .POS_W        (PW)
    ) u_enc (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (accept),
      .advance    (state == RUN),
      .weight     (weight[i]),
      .base       (base),
      .nz         (nz[i]),
      .en         (en[i]),
      .sign       (sign[i]),
      .pos        (pos[i]),
      .offset     (offset[i]),
      .empty_next (empty_next[i])
    );
  end

  // common base: smallest pending bit position over non-empty lanes
  always_comb begin
    base   = '1;
    any_nz = 1'b0;
    for (int i = 0; i < VEC_LENGTH; i++)
      if (nz[i] && (pos[i] < base)) base = pos[i];
    for (int i = 0; i < VEC_LENGTH; i++)
      any_nz = any_nz | nz[i];
    if (!any_nz) base = '0;
  end

  // per-lane signed term, offset shift, adder tree, then common base shift
  always_comb begin
    logic [DATA_WIDTH:0] a_ext, a_sel;
    logic [TW-1:0]       t;
    sum = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      a_ext = {act_q[i][DATA_WIDTH-1], act_q[i]};
      a_sel = sign[i] ? -a_ext : a_ext;
      t     = {{(TW-DATA_WIDTH-1){a_sel[DATA_WIDTH]}}, a_sel} << offset[i];
      if (en[i]) sum = sum + {{(SW-TW){t[TW-1]}}, t};
    end
    psum_nxt = {{DATA_WIDTH{sum[SW-1]}}, sum} << base;
  end

  // narrowing truncates (wrap), widening sign-extends
  assign psum_ext = ACC_WIDTH'(psum_reg);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (all_empty) state_nxt = DRAIN;
      DRAIN:   state_nxt = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      act_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        act_q  <= act;
        last_q <= in_last;
      end
    end
  end

  // psum_reg is zero outside RUN, so adding it on every RUN/DRAIN cycle
  // accumulates each round exactly once, one cycle behind its issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psum_reg <= '0;
      acc      <= '0;
    end else begin
      psum_reg <= (state == RUN) ? psum_nxt : '0;
      if (accept && in_first)
        acc <= '0;
      else if (state == RUN || state == DRAIN)
        acc <= acc + psum_ext;
    end
  end

`ifdef PRAGMATIC_MAC_STATS_EN
  localparam int NSW = $clog2(VEC_LENGTH + 1);
  logic [NSW-1:0] n_stall;
  logic [16:0]    stall_sum;

  always_comb begin
    n_stall = '0;
    for (int i = 0; i < VEC_LENGTH; i++)
      if (nz[i] && !en[i]) n_stall = n_stall + NSW'(1);
    stall_sum = 17'(stat_stalls) + 17'(n_stall);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rounds <= '0;
      stat_stalls <= '0;
    end else if (accept && in_first) begin
      stat_rounds <= '0;
      stat_stalls <= '0;
    end else if (state == RUN) begin
      if (stat_rounds != 16'hFFFF) stat_rounds <= stat_rounds + 16'd1;
      stat_stalls <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pragmatic_mac_seq.sv
// Directed bench: instance A (ACC_WIDTH=16, RESULT_WIDTH=16) runs a vector
// table plus multi-group, backpressure and reset sequences; instance B
// (default widths) runs the full-scale -128 x -128 case.
module tb_pragmatic_mac_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // instance A
  logic             in_valid_a, in_ready_a, in_first_a, in_last_a;
  logic [7:0][7:0]  act_a, weight_a;
  logic             out_valid_a, out_ready_a;
  logic [15:0]      result_a;
  // instance B
  logic             in_valid_b, in_ready_b, in_first_b, in_last_b;
  logic [7:0][7:0]  act_b, weight_b;
  logic             out_valid_b, out_ready_b;
  logic [15:0]      result_b;
`ifdef PRAGMATIC_MAC_STATS_EN
  logic [15:0] stat_rounds_a, stat_stalls_a, stat_rounds_b, stat_stalls_b;
`endif

  pragmatic_mac_seq #(.DATA_WIDTH(8), .VEC_LENGTH(8), .OFFSET_WIDTH(2),
                      .ACC_WIDTH(16), .RESULT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_first(in_first_a), .in_last(in_last_a), .act(act_a), .weight(weight_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .result(result_a)
`ifdef PRAGMATIC_MAC_STATS_EN
    , .stat_rounds(stat_rounds_a), .stat_stalls(stat_stalls_a)
`endif
  );

  pragmatic_mac_seq dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_first(in_first_b), .in_last(in_last_b), .act(act_b), .weight(weight_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .result(result_b)
`ifdef PRAGMATIC_MAC_STATS_EN
    , .stat_rounds(stat_rounds_b), .stat_stalls(stat_stalls_b)
`endif
  );

  typedef struct {
    string           name;
    logic [7:0][7:0] act;
    logic [7:0][7:0] w;
    int              res;
    int              lat;     // cycles from accept cycle to out_valid = R+2
    int              stalls;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[9];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [7:0] a0, w0, a1, w1, ar, wr,
                              input int res, lat, st);
    vec_t v;
    v.name = n;
    for (int i = 0; i < 8; i++) begin
      v.act[i] = ar;
      v.w[i]   = wr;
    end
    v.act[0] = a0; v.w[0] = w0;
    v.act[1] = a1; v.w[1] = w1;
    v.res = res; v.lat = lat; v.stalls = st;
    return v;
  endfunction

  // Starts and ends at posedge+1. Waits for in_ready, offers the group,
  // measures latency, checks result, then consumes it.
  task automatic run_a(input vec_t v, input logic first);
    int n;
    bit got;
    n = 0;
    while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
    chk({v.name, ".in_ready"}, int'(in_ready_a), 1);
    act_a = v.act; weight_a = v.w;
    in_first_a = first; in_last_a = 1'b1; in_valid_a = 1'b1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      in_valid_a = 1'b0;
      if (out_valid_a) got = 1;
    end
    chk({v.name, ".latency"}, n, v.lat);
    if (!got) return;
    chk({v.name, ".result"}, int'($signed(result_a)), v.res);
    chk({v.name, ".busy"}, int'(in_ready_a), 0);
`ifdef PRAGMATIC_MAC_STATS_EN
    if (first) begin
      chk({v.name, ".stat_rounds"}, int'(stat_rounds_a), v.lat - 2);
      chk({v.name, ".stat_stalls"}, int'(stat_stalls_a), v.stalls);
    end
`endif
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
  endtask

  // offer a non-last group and wait until it has drained back to IDLE
  task automatic send_mid(input vec_t v, input logic first, output int seen_valid);
    int n;
    seen_valid = 0;
    act_a = v.act; weight_a = v.w;
    in_first_a = first; in_last_a = 1'b0; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    n = 0;
    while (!in_ready_a && n < 20) begin
      if (out_valid_a) seen_valid++;
      @(posedge clk); #1; n++;
    end
    if (out_valid_a) seen_valid++;
    chk({v.name, ".returns_idle"}, int'(in_ready_a), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    vec_t m;
    // act0, w0, act1, w1, rest act, rest w, result, latency, stalls
    vecs[0] = mk("mul3x5",     8'd3,   8'd5,   8'd0, 8'd0,  8'd0, 8'd0,   15,    4, 0);
    vecs[1] = mk("win_stall",  8'd2,   8'd1,   8'd1, 8'd32, 8'd0, 8'd0,   34,    4, 1);
    vecs[2] = mk("three_bit",  8'd1,   8'd7,   8'd0, 8'd0,  8'd0, 8'd0,   7,     5, 0);
    vecs[3] = mk("all_zero",   8'd9,   8'd0,   8'd4, 8'd0,  8'd0, 8'd0,   0,     3, 0);
    vecs[4] = mk("neg_act",    8'hFB,  8'd3,   8'd0, 8'd0,  8'd0, 8'd0,   -15,   4, 0);
    vecs[5] = mk("all_m1",     8'd1,   8'hFF,  8'd1, 8'hFF, 8'd1, 8'hFF,  -8,    3, 0);
    vecs[6] = mk("min_sq",     8'h80,  8'h80,  8'd0, 8'd0,  8'd0, 8'd0,   16384, 3, 0);
    vecs[7] = mk("max_pop",    8'd127, 8'd127, 8'd0, 8'd0,  8'd0, 8'd0,   16129, 9, 0);
    vecs[8] = mk("two_stall",  8'd3,   8'd3,   8'd5, 8'd96, 8'd0, 8'd0,   489,   6, 2);

    reset_n = 1'b0;
    in_valid_a = 0; in_first_a = 0; in_last_a = 0; out_ready_a = 0; act_a = '0; weight_a = '0;
    in_valid_b = 0; in_first_b = 0; in_last_b = 0; out_ready_b = 0; act_b = '0; weight_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", int'(out_valid_a), 0);
    chk("reset.result", int'(result_a), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.in_ready", int'(in_ready_a), 1);

    for (int i = 0; i < 9; i++) run_a(vecs[i], 1'b1);

    // default-width instance: full-scale product in every lane
    act_b = {8{8'h80}}; weight_b = {8{8'h80}};
    in_first_b = 1; in_last_b = 1; in_valid_b = 1;
    n = 0;
    while (!out_valid_b && n < 40) begin @(posedge clk); #1; n++; in_valid_b = 0; end
    chk("dflt.latency", n, 3);
    chk("dflt.result", int'($signed(result_b)), 512);
    out_ready_b = 1; @(posedge clk); #1; out_ready_b = 0;
    chk("dflt.reaccept", int'(in_ready_b), 1);

    // three accumulated groups, result only after the last
    m = mk("grp", 8'd1, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, -3, 3, 0);
    send_mid(m, 1'b1, seen);
    chk("grp1.no_out_valid", seen, 0);
    send_mid(m, 1'b0, seen);
    chk("grp2.no_out_valid", seen, 0);
    run_a(m, 1'b0);

    // backpressure: result held while out_ready is low
    act_a = '0; weight_a = '0; in_first_a = 1; in_last_a = 1; in_valid_a = 1;
    n = 0;
    while (!out_valid_a && n < 40) begin @(posedge clk); #1; n++; in_valid_a = 0; end
    chk("hold.latency", n, 3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold.out_valid", int'(out_valid_a), 1);
      chk("hold.result", int'(result_a), 0);
      chk("hold.in_ready", int'(in_ready_a), 0);
    end
    out_ready_a = 1;
    @(posedge clk); #1;
    out_ready_a = 0;
    chk("hold.release_ready", int'(in_ready_a), 1);
    chk("hold.release_valid", int'(out_valid_a), 0);

    // reset during RUN of a three-round group after one round has landed in acc
    act_a = vecs[2].act; weight_a = vecs[2].w; in_first_a = 1; in_last_a = 1; in_valid_a = 1;
    @(posedge clk); #1; in_valid_a = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort.out_valid", int'(out_valid_a), 0);
    chk("abort.acc", int'(result_a), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.in_ready", int'(in_ready_a), 1);
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid_a) n++; end
    chk("abort.no_output", n, 0);
    // without in_first: result is correct only if reset cleared acc
    run_a(vecs[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
